neuron_mac: RTL

//  Per-neuron multiply-accumulate stage directly downstream of the weight memory.

---
 rtl/neuron_mac.sv | 125 ++++++++++++
 1 files changed

// File: rtl/neuron_mac.sv
// Per-neuron MAC: streams activations against weights read from memory, accumulates,
// adds bias and emits one saturated sum per vector. Define NEURON_RELU_EN to clamp negatives to 0.
module neuron_mac #(
  parameter int numWeight    = 3,
  parameter int addressWidth = 10,
  parameter int dataWidth    = 16,
  parameter int fracWidth    = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    biasValid,
  input  logic [dataWidth-1:0]    biasIn,
  input  logic [dataWidth-1:0]    myinput,
  input  logic                    myinputValid,
  output logic                    inReady,
  output logic                    ren,
  output logic [addressWidth-1:0] radd,
  input  logic [dataWidth-1:0]    wout,
  output logic [dataWidth-1:0]    outSum,
  output logic                    outValid
);

  localparam int PW = 2 * dataWidth;
  localparam int AW = PW + $clog2(numWeight);
  localparam int SW = AW + 1;
  localparam logic [addressWidth-1:0] LAST_IDX = addressWidth'(numWeight - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'(2 ** (dataWidth - 1) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {IDLE, RUN} state_t;

  state_t state, state_nxt;

  logic [addressWidth-1:0]     idx;
  logic signed [dataWidth-1:0] bias;
  logic                        accept, first, last;

  logic                        s1_v, s1_first, s1_last;
  logic signed [dataWidth-1:0] s1_act;
  logic signed [PW-1:0]        prod;

  logic                        s2_v, s2_first, s2_last;
  logic signed [PW-1:0]        s2_prodq;

  logic signed [AW-1:0]        acc, acc_nxt, prodq_x;
  logic signed [SW-1:0]        sum;
  logic [dataWidth-1:0]        res;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    inReady   = 1'b0;
    if (state == IDLE) begin
      if (biasValid) state_nxt = RUN;
    end else begin
      inReady = 1'b1;
    end
  end

  assign accept = myinputValid & inReady;
  assign ren    = accept;
  assign radd   = idx;
  assign first  = (idx == '0);
  assign last   = (idx == LAST_IDX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            bias <= '0;
    else if (biasValid) bias <= biasIn;
  end

  assign prod    = PW'(s1_act) * PW'($signed(wout));
  assign prodq_x = AW'(s2_prodq);

  // Final add is folded into the S2->S3 edge so the last term, the running
  // accumulator and the bias combine in one cycle, giving the 3-cycle latency.
  always_comb begin
    acc_nxt = s2_first ? prodq_x : acc + prodq_x;
    sum     = SW'(acc_nxt) + SW'(bias);
    if (sum > SAT_MAX)      res = {1'b0, {(dataWidth-1){1'b1}}};
    else if (sum < SAT_MIN) res = {1'b1, {(dataWidth-1){1'b0}}};
    else                    res = sum[dataWidth-1:0];
`ifdef NEURON_RELU_EN
    if (sum < 0) res = '0;
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      s1_v     <= 1'b0;
      s1_first <= 1'b0;
      s1_last  <= 1'b0;
      s1_act   <= '0;
      s2_v     <= 1'b0;
      s2_first <= 1'b0;
      s2_last  <= 1'b0;
      s2_prodq <= '0;
      acc      <= '0;
      outSum   <= '0;
      outValid <= 1'b0;
    end else begin
      s1_v <= accept;
      if (accept) begin
        s1_act   <= myinput;
        s1_first <= first;
        s1_last  <= last;
        idx      <= last ? '0 : idx + addressWidth'(1);
      end
      s2_v <= s1_v;
      if (s1_v) begin
        s2_prodq <= prod >>> fracWidth;
        s2_first <= s1_first;
        s2_last  <= s1_last;
      end
      if (s2_v) acc <= acc_nxt;
      outValid <= s2_v & s2_last;
      if (s2_v && s2_last) outSum <= res;
    end
  end

endmodule
